// File: rtl/dmem_responder_if.sv
// Load/store bus between the Mem stage (master) and the data-memory
// responder (slave). Req/Ack handshake with request fields captured on Req.
interface dmem_responder_if;
    logic        Req;
    logic        WE;
    logic [31:0] Address;
    logic [31:0] DataIn;
    logic [3:0]  ByteEn;
    logic        Ack;
    logic [31:0] DataOut;
    logic        Err;

    modport master (
        output Req, WE, Address, DataIn, ByteEn,
        input  Ack, DataOut, Err
    );

    modport slave (
        input  Req, WE, Address, DataIn, ByteEn,
        output Ack, DataOut, Err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one request in IDLE, waits WAIT_CYCLES,
// then performs the word read or write on the access edge into RESP and
// strobes Ack for one cycle. Misaligned or out-of-window addresses give Err.
// Optional feature: define DMEM_BYTE_EN_EN to honour ByteEn lane enables on
// writes; without it every write updates the full word.
module dmem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  cnt_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic        ack_r;
    logic        err_r;
    logic [31:0] dout_r;
    logic [31:0] mem_r [DEPTH];

    logic             op_we_s;
    logic [31:0]      op_addr_s;
    logic [31:0]      op_data_s;
    logic [31:0]      offset_s;
    logic [31:0]      wr_word_s;
    logic [IDX_W-1:0] idx_s;
    logic             err_s;
    logic             access_s;

`ifdef DMEM_BYTE_EN_EN
    logic [3:0] be_r;
    logic [3:0] op_be_s;

    // Replace only the enabled byte lanes of the stored word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                w[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                w[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return w;
    endfunction
`else
    logic unused_be_s;
    assign unused_be_s = ^bus.ByteEn;
`endif

    // Operand select: with zero wait states the access edge is the capture
    // edge, so the live bus fields are used while still in IDLE.
    always_comb begin
        if (state_r == IDLE) begin
            op_we_s   = bus.WE;
            op_addr_s = bus.Address;
            op_data_s = bus.DataIn;
`ifdef DMEM_BYTE_EN_EN
            op_be_s   = bus.ByteEn;
`endif
        end else begin
            op_we_s   = we_r;
            op_addr_s = addr_r;
            op_data_s = data_r;
`ifdef DMEM_BYTE_EN_EN
            op_be_s   = be_r;
`endif
        end
    end

    // Address decode: any offset at or beyond the window is an error, never an alias.
    always_comb begin
        offset_s = op_addr_s - ADDR_BASE;
        err_s    = (op_addr_s[1:0] != 2'b00) || ((offset_s >> (IDX_W + 2)) != 32'd0);
        idx_s    = offset_s[IDX_W+1:2];
`ifdef DMEM_BYTE_EN_EN
        wr_word_s = merge_lanes(mem_r[idx_s], op_data_s, op_be_s);
`else
        wr_word_s = op_data_s;
`endif
    end

    // Next-state logic; the access happens on whichever edge enters RESP.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.Req) begin
                    state_s = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        access_s = (state_s == RESP) && !Reset;
    end

    // Control state, request holding registers and registered response outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= 32'd0;
            data_r  <= 32'd0;
`ifdef DMEM_BYTE_EN_EN
            be_r    <= 4'd0;
`endif
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dout_r  <= 32'd0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && bus.Req) begin
                we_r   <= bus.WE;
                addr_r <= bus.Address;
                data_r <= bus.DataIn;
`ifdef DMEM_BYTE_EN_EN
                be_r   <= bus.ByteEn;
`endif
            end
            if ((state_r == IDLE) && (state_s == WAIT)) begin
                cnt_r <= WAIT_LOAD;
            end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
            ack_r <= access_s;
            if (access_s) begin
                err_r <= err_s;
                if (err_s || op_we_s) begin
                    dout_r <= 32'd0;
                end else begin
                    dout_r <= mem_r[idx_s];
                end
            end else if (state_r == RESP) begin
                err_r <= 1'b0;
            end
        end
    end

    // Word array write on the access edge; contents survive reset.
    always_ff @(posedge Clk) begin
        if (access_s && op_we_s && !err_s) begin
            mem_r[idx_s] <= wr_word_s;
        end
    end

    assign bus.Ack     = ack_r;
    assign bus.DataOut = dout_r;
    assign bus.Err     = err_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a WAIT_CYCLES=2 instance for
// latency, error, reset and random traffic, and a WAIT_CYCLES=0 instance
// for back-to-back requests. Expected values come from an address-keyed model.
module tb_dmem_responder;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned DEPTH = 256;

    logic Clk = 1'b0;
    logic Reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] model_mem [int unsigned];

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    dmem_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a)
    );
    dmem_responder #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b)
    );

    always #5 Clk = ~Clk;

    function automatic logic model_err(input logic [31:0] addr);
        longint unsigned off;
        off = longint'(addr - BASE) & 64'hFFFF_FFFF;
        return (addr % 32'd4 != 32'd0) || (off >= 64'd4 * DEPTH);
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] be);
        int unsigned key;
        logic [31:0] w;
        key = (addr - BASE) / 32'd4;
        w = model_mem.exists(key) ? model_mem[key] : 32'd0;
`ifdef DMEM_BYTE_EN_EN
        for (int i = 0; i < 4; i++) if (be[i]) w = (w & ~(32'hFF << (8*i))) | (data & (32'hFF << (8*i)));
`else
        w = data;
        if (be == 4'hF) w = data;
`endif
        model_mem[key] = w;
    endfunction

    // One transaction on bus_a; Req driven right after edge E0 and held until Ack.
    task automatic txn_a(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output logic [31:0] dout, output logic err,
                         output int lat, output logic clean_after);
        bus_a.Req = 1'b1; bus_a.WE = we; bus_a.Address = addr;
        bus_a.DataIn = data; bus_a.ByteEn = be;
        dout = 32'd0; err = 1'b0; lat = -1; clean_after = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge Clk); #1;
            if (bus_a.Ack === 1'b1) begin
                lat = j; dout = bus_a.DataOut; err = bus_a.Err;
                break;
            end
        end
        bus_a.Req = 1'b0;
        @(posedge Clk); #1;
        clean_after = (bus_a.Ack === 1'b0) && (bus_a.Err === 1'b0);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        bus_a.Req = 1'b0; bus_a.WE = 1'b0; bus_a.Address = 32'd0; bus_a.DataIn = 32'd0; bus_a.ByteEn = 4'd0;
        bus_b.Req = 1'b0; bus_b.WE = 1'b0; bus_b.Address = 32'd0; bus_b.DataIn = 32'd0; bus_b.ByteEn = 4'd0;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (bus_a.Ack !== 1'b0) begin errors++; $display("FAIL reset_ack_a: got %b expected 0", bus_a.Ack); end
        checks++; if (bus_a.Err !== 1'b0) begin errors++; $display("FAIL reset_err_a: got %b expected 0", bus_a.Err); end
        checks++; if (bus_a.DataOut !== 32'd0) begin errors++; $display("FAIL reset_dout_a: got %h expected 0", bus_a.DataOut); end
        checks++; if (bus_b.Ack !== 1'b0) begin errors++; $display("FAIL reset_ack_b: got %b expected 0", bus_b.Ack); end
        checks++; if (bus_b.Err !== 1'b0) begin errors++; $display("FAIL reset_err_b: got %b expected 0", bus_b.Err); end
        checks++; if (bus_b.DataOut !== 32'd0) begin errors++; $display("FAIL reset_dout_b: got %h expected 0", bus_b.DataOut); end
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_write_read;
        logic [31:0] d; logic e, c; int l;
        txn_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, l, c);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        checks++; if (l != 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", l); end
        checks++; if (e !== 1'b0 || d !== 32'd0) begin errors++; $display("FAIL wr_resp: got err=%b dout=%h expected err=0 dout=0", e, d); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL wr_ack_one_cycle: got clean=%b expected 1", c); end
        txn_a(1'b0, 32'h10, 32'h0, 4'h0, d, e, l, c);
        checks++; if (l != 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", l); end
        checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL rd_data: got %h err=%b expected deadbeef err=0", d, e); end
    endtask

    task automatic test_misaligned;
        logic [31:0] d; logic e, c; int l;
        txn_a(1'b0, 32'h12, 32'h0, 4'h0, d, e, l, c);
        checks++; if (e !== 1'b1 || d !== 32'd0 || l != 3) begin errors++; $display("FAIL misaligned: got err=%b dout=%h lat=%0d expected err=1 dout=0 lat=3", e, d, l); end
        checks++; if (c !== 1'b1) begin errors++; $display("FAIL misaligned_err_clear: got clean=%b expected 1", c); end
        txn_a(1'b0, 32'h10, 32'h0, 4'h0, d, e, l, c);
        checks++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL after_misaligned: got %h err=%b expected deadbeef err=0", d, e); end
    endtask

    task automatic test_out_of_window;
        logic [31:0] d; logic e, c; int l;
        txn_a(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, d, e, l, c);
        model_write(32'h0, 32'hCAFEF00D, 4'hF);
        txn_a(1'b1, BASE + 32'(4 * DEPTH), 32'h12345678, 4'hF, d, e, l, c);
        checks++; if (e !== 1'b1 || d !== 32'd0) begin errors++; $display("FAIL oow_write: got err=%b dout=%h expected err=1 dout=0", e, d); end
        txn_a(1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'hF, d, e, l, c);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oow_top: got err=%b expected 1", e); end
        txn_a(1'b0, 32'h0, 32'h0, 4'h0, d, e, l, c);
        checks++; if (d !== 32'hCAFEF00D || e !== 1'b0) begin errors++; $display("FAIL no_alias: got %h err=%b expected cafef00d err=0", d, e); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic e, c; int l; logic seen;
        txn_a(1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, d, e, l, c);
        model_write(32'h20, 32'hA5A5A5A5, 4'hF);
        txn_a(1'b0, 32'h20, 32'h0, 4'h0, d, e, l, c);
        bus_a.Req = 1'b1; bus_a.WE = 1'b1; bus_a.Address = 32'h20; bus_a.DataIn = 32'h55; bus_a.ByteEn = 4'hF;
        @(posedge Clk); #1;
        bus_a.Req = 1'b0;
        #2 Reset = 1'b1;
        #2 Reset = 1'b0;
        checks++; if (bus_a.DataOut !== 32'd0 || bus_a.Ack !== 1'b0 || bus_a.Err !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got ack=%b err=%b dout=%h expected all 0", bus_a.Ack, bus_a.Err, bus_a.DataOut); end
        seen = 1'b0;
        repeat (6) begin @(posedge Clk); #1; if (bus_a.Ack === 1'b1) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_no_ack: got ack seen=%b expected 0", seen); end
        txn_a(1'b0, 32'h20, 32'h0, 4'h0, d, e, l, c);
        checks++; if (d !== 32'hA5A5A5A5) begin errors++; $display("FAIL mid_reset_discard: got %h expected a5a5a5a5", d); end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] d; logic e, c; int l; logic [31:0] exp_w;
        txn_a(1'b1, 32'h8, 32'h11223344, 4'hF, d, e, l, c);
        txn_a(1'b1, 32'h8, 32'h0000AA00, 4'b0010, d, e, l, c);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL lane_write_err: got %b expected 0", e); end
`ifdef DMEM_BYTE_EN_EN
        exp_w = 32'h1122AA44;
`else
        exp_w = 32'h0000AA00;
`endif
        txn_a(1'b0, 32'h8, 32'h0, 4'h0, d, e, l, c);
        checks++; if (d !== exp_w) begin errors++; $display("FAIL lane_read: got %h expected %h", d, exp_w); end
`ifdef DMEM_BYTE_EN_EN
        txn_a(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, d, e, l, c);
        checks++; if (e !== 1'b0 || l != 3) begin errors++; $display("FAIL noop_write: got err=%b lat=%0d expected err=0 lat=3", e, l); end
        txn_a(1'b0, 32'h8, 32'h0, 4'h0, d, e, l, c);
        checks++; if (d !== exp_w) begin errors++; $display("FAIL noop_unchanged: got %h expected %h", d, exp_w); end
`endif
    endtask

    task automatic test_random;
        logic [31:0] d, addr, data, exp_d; logic e, c, we, exp_e; int l; logic [3:0] be; int unsigned kind, key;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            data = $urandom;
            be   = 4'($urandom_range(0, 15));
            we   = 1'($urandom_range(0, 1));
            if (kind == 0) addr = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
            else if (kind == 1) addr = 32'h400 + 32'($urandom_range(0, 4000)) * 32'd4;
            else addr = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
            exp_e = model_err(addr);
            key = (addr - BASE) / 32'd4;
            if (!exp_e && !model_mem.exists(key)) begin we = 1'b1; be = 4'hF; end
            exp_d = (exp_e || we) ? 32'd0 : model_mem[key];
            txn_a(we, addr, data, be, d, e, l, c);
            if (!exp_e && we) model_write(addr, data, be);
            checks++;
            if (d !== exp_d || e !== exp_e || l != 3 || c !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d: addr=%h we=%b got dout=%h err=%b lat=%0d clean=%b expected dout=%h err=%b lat=3 clean=1",
                         n, addr, we, d, e, l, c, exp_d, exp_e);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] t_addr [4]; logic t_we [4]; logic [31:0] t_data [4]; logic [31:0] t_exp [4];
        logic exp_ack; int k;
        t_data[0] = $urandom; t_data[2] = $urandom; t_data[1] = 32'd0; t_data[3] = 32'd0;
        t_addr[0] = 32'h40; t_addr[1] = 32'h40; t_addr[2] = 32'h44; t_addr[3] = 32'h44;
        t_we[0] = 1'b1; t_we[1] = 1'b0; t_we[2] = 1'b1; t_we[3] = 1'b0;
        t_exp[0] = 32'd0; t_exp[1] = t_data[0]; t_exp[2] = 32'd0; t_exp[3] = t_data[2];
        k = 0;
        bus_b.Req = 1'b1; bus_b.WE = t_we[0]; bus_b.Address = t_addr[0]; bus_b.DataIn = t_data[0]; bus_b.ByteEn = 4'hF;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge Clk); #1;
            exp_ack = (cyc % 2 == 1);
            checks++; if (bus_b.Ack !== exp_ack) begin errors++; $display("FAIL b2b_ack_cycle%0d: got %b expected %b", cyc, bus_b.Ack, exp_ack); end
            if (bus_b.Ack === 1'b1 && k < 4) begin
                checks++;
                if (bus_b.DataOut !== t_exp[k] || bus_b.Err !== 1'b0) begin errors++; $display("FAIL b2b_txn%0d: got dout=%h err=%b expected dout=%h err=0", k, bus_b.DataOut, bus_b.Err, t_exp[k]); end
                k++;
                if (k < 4) begin bus_b.WE = t_we[k]; bus_b.Address = t_addr[k]; bus_b.DataIn = t_data[k]; end
            end
        end
        bus_b.Req = 1'b0;
        checks++; if (k != 4) begin errors++; $display("FAIL b2b_count: got %0d acks expected 4", k); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_out_of_window();
        test_reset_mid();
        test_byte_lanes();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
